// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates Dcache, Icache and prefetcher requests onto a
// single memory command bus. Returned data tags are routed back to the
// requester that owns each tag. The request and return paths are purely
// combinational, so the arbiter adds no latency. The age counter keeps the
// prefetcher from being starved by the Icache.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  d_cmd_i,
    input  logic [63:0] d_addr_i,
    input  logic [63:0] d_data_i,
    input  logic [1:0]  i_cmd_i,
    input  logic [63:0] i_addr_i,
    input  logic [1:0]  p_cmd_i,
    input  logic [63:0] p_addr_i,
    input  logic [3:0]  mem_response_i,
    input  logic [3:0]  mem_tag_i,
    output logic [1:0]  mem_cmd_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_data_o,
    output logic [3:0]  d_response_o,
    output logic [3:0]  i_response_o,
    output logic [3:0]  p_response_o,
    output logic [3:0]  d_tag_o,
    output logic [3:0]  i_tag_o,
    output logic [3:0]  p_tag_o
);

    localparam logic [1:0] BUS_NONE = 2'd0;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
    typedef enum logic [1:0] {OWN_D = 2'd0, OWN_I = 2'd1, OWN_P = 2'd2} owner_t;

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [2:0] age_q, age_d;

    // Owner table, one entry per nonzero memory tag.
    logic       tbl_valid_q [1:15];
    logic       tbl_valid_d [1:15];
    owner_t     tbl_owner_q [1:15];
    owner_t     tbl_owner_d [1:15];

    logic   d_pend, i_pend, p_pend;
    logic   grant_vld;
    owner_t grant_owner;
    logic   ack;
    logic   ret_hit;
    owner_t ret_owner;

    assign d_pend = (d_cmd_i != BUS_NONE);
    assign i_pend = (i_cmd_i != BUS_NONE);
    assign p_pend = (p_cmd_i != BUS_NONE);

    // Grant selection: the locked owner has exclusive use of the bus; otherwise
    // the fixed priority is D > I > P, and P moves ahead of I once it has aged.
    always_comb begin
        grant_vld   = 1'b0;
        grant_owner = OWN_D;
        if (!rst) begin
            if (state_q == ST_LOCKED) begin
                grant_owner = owner_q;
                case (owner_q)
                    OWN_D:   grant_vld = d_pend;
                    OWN_I:   grant_vld = i_pend;
                    OWN_P:   grant_vld = p_pend;
                    default: grant_vld = 1'b0;
                endcase
            end else if (d_pend) begin
                grant_vld   = 1'b1;
                grant_owner = OWN_D;
            end else if (p_pend && age_q == 3'd7) begin
                grant_vld   = 1'b1;
                grant_owner = OWN_P;
            end else if (i_pend) begin
                grant_vld   = 1'b1;
                grant_owner = OWN_I;
            end else if (p_pend) begin
                grant_vld   = 1'b1;
                grant_owner = OWN_P;
            end
        end
    end

    assign ack = grant_vld && (mem_response_i != 4'd0);

    // Forward the grantee's request to memory. Only the Dcache carries store data.
    always_comb begin
        mem_cmd_o  = BUS_NONE;
        mem_addr_o = 64'd0;
        mem_data_o = 64'd0;
        if (grant_vld) begin
            case (grant_owner)
                OWN_D: begin
                    mem_cmd_o  = d_cmd_i;
                    mem_addr_o = d_addr_i;
                    mem_data_o = d_data_i;
                end
                OWN_I: begin
                    mem_cmd_o  = i_cmd_i;
                    mem_addr_o = i_addr_i;
                end
                OWN_P: begin
                    mem_cmd_o  = p_cmd_i;
                    mem_addr_o = p_addr_i;
                end
                default: ;
            endcase
        end
    end

    // Route the memory ack to the grantee only.
    always_comb begin
        d_response_o = (ack && grant_owner == OWN_D) ? mem_response_i : 4'd0;
        i_response_o = (ack && grant_owner == OWN_I) ? mem_response_i : 4'd0;
        p_response_o = (ack && grant_owner == OWN_P) ? mem_response_i : 4'd0;
    end

    // Look up the owner of the returning tag; tags without a valid entry are dropped.
    always_comb begin
        ret_hit   = 1'b0;
        ret_owner = OWN_D;
        for (int k = 1; k < 16; k++) begin
            if (!rst && mem_tag_i == 4'(k) && tbl_valid_q[k]) begin
                ret_hit   = 1'b1;
                ret_owner = tbl_owner_q[k];
            end
        end
    end

    // Route the returned tag to its owner.
    always_comb begin
        d_tag_o = (ret_hit && ret_owner == OWN_D) ? mem_tag_i : 4'd0;
        i_tag_o = (ret_hit && ret_owner == OWN_I) ? mem_tag_i : 4'd0;
        p_tag_o = (ret_hit && ret_owner == OWN_P) ? mem_tag_i : 4'd0;
    end

    // Owner table update. A return invalidates its entry first; a new ack is
    // applied afterwards, so it wins when both name the same tag.
    always_comb begin
        tbl_valid_d = tbl_valid_q;
        tbl_owner_d = tbl_owner_q;
        for (int k = 1; k < 16; k++) begin
            if (ret_hit && mem_tag_i == 4'(k)) begin
                tbl_valid_d[k] = 1'b0;
            end
            if (ack && mem_response_i == 4'(k)) begin
                tbl_valid_d[k] = 1'b1;
                tbl_owner_d[k] = grant_owner;
            end
        end
    end

    // Next state for the lock FSM and the prefetch age counter.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        age_d   = age_q;
        if (grant_vld) begin
            if (ack) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_LOCKED;
                owner_d = grant_owner;
            end
        end else begin
            // Either nothing is pending, or the locked owner has withdrawn.
            state_d = ST_IDLE;
        end

        if (!p_pend) begin
            age_d = 3'd0;
        end else if (ack && grant_owner == OWN_P) begin
            age_d = 3'd0;
        end else if (!(grant_vld && grant_owner == OWN_P) && age_q != 3'd7) begin
            age_d = age_q + 3'd1;
        end
    end

    // State registers; reset overrides every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_D;
            age_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            age_q   <= age_d;
        end
    end

    // Owner table registers; reset discards every outstanding tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < 16; k++) begin
                tbl_valid_q[k] <= 1'b0;
                tbl_owner_q[k] <= OWN_D;
            end
        end else begin
            tbl_valid_q <= tbl_valid_d;
            tbl_owner_q <= tbl_owner_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter. Inputs change 1 time unit after a
// rising edge; combinational outputs are checked on the falling edge.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  d_cmd_i, i_cmd_i, p_cmd_i;
    logic [63:0] d_addr_i, d_data_i, i_addr_i, p_addr_i;
    logic [3:0]  mem_response_i, mem_tag_i;
    logic [1:0]  mem_cmd_o;
    logic [63:0] mem_addr_o, mem_data_o;
    logic [3:0]  d_response_o, i_response_o, p_response_o;
    logic [3:0]  d_tag_o, i_tag_o, p_tag_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] A_D = 64'h1000;
    localparam logic [63:0] A_I = 64'h2000;
    localparam logic [63:0] A_P = 64'h3000;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .d_cmd_i        (d_cmd_i),
        .d_addr_i       (d_addr_i),
        .d_data_i       (d_data_i),
        .i_cmd_i        (i_cmd_i),
        .i_addr_i       (i_addr_i),
        .p_cmd_i        (p_cmd_i),
        .p_addr_i       (p_addr_i),
        .mem_response_i (mem_response_i),
        .mem_tag_i      (mem_tag_i),
        .mem_cmd_o      (mem_cmd_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .d_response_o   (d_response_o),
        .i_response_o   (i_response_o),
        .p_response_o   (p_response_o),
        .d_tag_o        (d_tag_o),
        .i_tag_o        (i_tag_o),
        .p_tag_o        (p_tag_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] dc, input logic [1:0] ic, input logic [1:0] pc,
                         input logic [3:0] resp, input logic [3:0] tg);
        d_cmd_i        = dc;
        i_cmd_i        = ic;
        p_cmd_i        = pc;
        mem_response_i = resp;
        mem_tag_i      = tg;
    endtask

    task automatic to_check;
        @(negedge clk);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        d_addr_i = A_D;
        d_data_i = 64'hDEAD_BEEF;
        i_addr_i = A_I;
        p_addr_i = A_P;

        // Reset cycle with a live request and tag: everything must stay quiet.
        drive(2'd1, 2'd0, 2'd0, 4'd3, 4'd2);
        to_check;
        chk("rst_mem_cmd",  64'(mem_cmd_o), 64'd0);
        chk("rst_mem_addr", mem_addr_o, 64'd0);
        chk("rst_d_resp",   64'(d_response_o), 64'd0);
        chk("rst_d_tag",    64'(d_tag_o), 64'd0);
        next_cycle;
        drive(2'd0, 2'd0, 2'd0, 4'd0, 4'd0);
        next_cycle;
        rst = 1'b0;

        // Idle after reset.
        to_check;
        chk("idle_mem_cmd",  64'(mem_cmd_o), 64'd0);
        chk("idle_mem_data", mem_data_o, 64'd0);
        next_cycle;

        // All three load at once, ack tag 3: Dcache wins.
        drive(2'd1, 2'd1, 2'd1, 4'd3, 4'd0);
        to_check;
        chk("all3_addr",   mem_addr_o, A_D);
        chk("all3_cmd",    64'(mem_cmd_o), 64'd1);
        chk("all3_d_resp", 64'(d_response_o), 64'd3);
        chk("all3_i_resp", 64'(i_response_o), 64'd0);
        chk("all3_p_resp", 64'(p_response_o), 64'd0);
        next_cycle;

        // Tag 3 returns to Dcache only.
        drive(2'd0, 2'd0, 2'd0, 4'd0, 4'd3);
        to_check;
        chk("ret3_d_tag", 64'(d_tag_o), 64'd3);
        chk("ret3_i_tag", 64'(i_tag_o), 64'd0);
        chk("ret3_p_tag", 64'(p_tag_o), 64'd0);
        next_cycle;

        // Tag 3 already retired: a second return is dropped.
        to_check;
        chk("ret3_again_d_tag", 64'(d_tag_o), 64'd0);
        next_cycle;

        // Dcache store forwards data, locks, then is acked with tag 6.
        drive(2'd2, 2'd0, 2'd0, 4'd0, 4'd0);
        d_data_i = 64'hCAFE;
        to_check;
        chk("st_cmd",  64'(mem_cmd_o), 64'd2);
        chk("st_data", mem_data_o, 64'hCAFE);
        next_cycle;
        drive(2'd2, 2'd0, 2'd0, 4'd6, 4'd0);
        to_check;
        chk("st_d_resp", 64'(d_response_o), 64'd6);
        next_cycle;

        // Lock on Icache holds off a later Dcache request.
        drive(2'd0, 2'd1, 2'd0, 4'd0, 4'd0);
        to_check;
        chk("lk1_addr",   mem_addr_o, A_I);
        chk("lk1_i_resp", 64'(i_response_o), 64'd0);
        next_cycle;
        drive(2'd1, 2'd1, 2'd0, 4'd0, 4'd0);
        to_check;
        chk("lk2_addr", mem_addr_o, A_I);
        chk("lk2_data", mem_data_o, 64'd0);
        next_cycle;
        drive(2'd1, 2'd1, 2'd0, 4'd5, 4'd0);
        to_check;
        chk("lk3_addr",   mem_addr_o, A_I);
        chk("lk3_i_resp", 64'(i_response_o), 64'd5);
        chk("lk3_d_resp", 64'(d_response_o), 64'd0);
        next_cycle;
        drive(2'd1, 2'd0, 2'd0, 4'd0, 4'd0);
        to_check;
        chk("lk4_addr", mem_addr_o, A_D);
        next_cycle;

        // Locked on Dcache, Dcache withdraws while Icache waits: bus idle that cycle.
        drive(2'd0, 2'd1, 2'd0, 4'd4, 4'd0);
        to_check;
        chk("wd_d_cmd",    64'(mem_cmd_o), 64'd0);
        chk("wd_d_i_resp", 64'(i_response_o), 64'd0);
        next_cycle;

        // Now Icache locks, then withdraws with Dcache waiting and an ack present.
        drive(2'd0, 2'd1, 2'd0, 4'd0, 4'd0);
        to_check;
        chk("wd_i_lock_addr", mem_addr_o, A_I);
        next_cycle;
        drive(2'd1, 2'd0, 2'd0, 4'd4, 4'd0);
        to_check;
        chk("wd_i_cmd",    64'(mem_cmd_o), 64'd0);
        chk("wd_i_addr",   mem_addr_o, 64'd0);
        chk("wd_i_d_resp", 64'(d_response_o), 64'd0);
        chk("wd_i_i_resp", 64'(i_response_o), 64'd0);
        next_cycle;
        drive(2'd1, 2'd0, 2'd0, 4'd1, 4'd0);
        to_check;
        chk("after_wd_addr",   mem_addr_o, A_D);
        chk("after_wd_d_resp", 64'(d_response_o), 64'd1);
        next_cycle;

        // Icache and prefetcher load continuously with an ack every cycle:
        // prefetcher wins on its 8th pending cycle.
        drive(2'd0, 2'd1, 2'd1, 4'd8, 4'd0);
        for (int c = 1; c <= 7; c++) begin
            to_check;
            chk($sformatf("age_c%0d_p_resp", c), 64'(p_response_o), 64'd0);
            chk($sformatf("age_c%0d_i_resp", c), 64'(i_response_o), 64'd8);
            next_cycle;
        end
        to_check;
        chk("age_c8_p_resp", 64'(p_response_o), 64'd8);
        chk("age_c8_addr",   mem_addr_o, A_P);
        chk("age_c8_i_resp", 64'(i_response_o), 64'd0);
        next_cycle;
        to_check;
        chk("age_c9_p_resp", 64'(p_response_o), 64'd0);
        chk("age_c9_i_resp", 64'(i_response_o), 64'd8);
        next_cycle;

        // Prefetcher takes tag 7.
        drive(2'd0, 2'd0, 2'd1, 4'd7, 4'd0);
        to_check;
        chk("p7_p_resp", 64'(p_response_o), 64'd7);
        next_cycle;

        // Same cycle: tag 7 returns (to P) and Dcache is acked with tag 7.
        drive(2'd1, 2'd0, 2'd0, 4'd7, 4'd7);
        to_check;
        chk("same7_p_tag",  64'(p_tag_o), 64'd7);
        chk("same7_d_tag",  64'(d_tag_o), 64'd0);
        chk("same7_d_resp", 64'(d_response_o), 64'd7);
        next_cycle;
        drive(2'd0, 2'd0, 2'd0, 4'd0, 4'd7);
        to_check;
        chk("new7_d_tag", 64'(d_tag_o), 64'd7);
        chk("new7_p_tag", 64'(p_tag_o), 64'd0);
        next_cycle;

        // Unallocated tag 9 is dropped; tag 8 was last acked to Icache.
        drive(2'd0, 2'd0, 2'd0, 4'd0, 4'd9);
        to_check;
        chk("t9_d_tag", 64'(d_tag_o), 64'd0);
        chk("t9_i_tag", 64'(i_tag_o), 64'd0);
        chk("t9_p_tag", 64'(p_tag_o), 64'd0);
        next_cycle;
        drive(2'd0, 2'd0, 2'd0, 4'd0, 4'd8);
        to_check;
        chk("t8_i_tag", 64'(i_tag_o), 64'd8);
        next_cycle;

        // Icache takes tag 4, then reset discards it.
        drive(2'd0, 2'd1, 2'd0, 4'd4, 4'd0);
        to_check;
        chk("t4_i_resp", 64'(i_response_o), 64'd4);
        next_cycle;
        rst = 1'b1;
        drive(2'd0, 2'd1, 2'd0, 4'd2, 4'd4);
        to_check;
        chk("rst2_i_tag",  64'(i_tag_o), 64'd0);
        chk("rst2_i_resp", 64'(i_response_o), 64'd0);
        chk("rst2_cmd",    64'(mem_cmd_o), 64'd0);
        next_cycle;
        rst = 1'b0;
        drive(2'd0, 2'd0, 2'd0, 4'd0, 4'd4);
        to_check;
        chk("post_rst_t4_i_tag", 64'(i_tag_o), 64'd0);
        next_cycle;
        drive(2'd0, 2'd0, 2'd0, 4'd0, 4'd1);
        to_check;
        chk("post_rst_t1_d_tag", 64'(d_tag_o), 64'd0);
        next_cycle;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
